// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      BR_FLUSH = 2'd2
   } hz_state_t;

   localparam int ZERO_REG          = 0;
   localparam int DEF_PC_WIDTH      = 15;
   localparam int DEF_REGADDR_WIDTH = 4;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating 16-bit event counter with synchronous clear; only built with HAZARD_PERF_CNT_EN.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for the IF/ID and ID/EX registers.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int PC_WIDTH          = DEF_PC_WIDTH,
   parameter int REGADDR_WIDTH     = DEF_REGADDR_WIDTH,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [REGADDR_WIDTH-1:0] id_rs,
   input  logic [REGADDR_WIDTH-1:0] id_rt,
   input  logic                     id_uses_rs,
   input  logic                     id_uses_rt,
   input  logic                     ex_mem_read,
   input  logic [REGADDR_WIDTH-1:0] ex_rt,
   input  logic                     ex_branch,
   input  logic                     ex_branch_taken,
   input  logic [PC_WIDTH-1:0]      ex_branch_target,
   output logic                     pc_stall,
   output logic                     if_id_stall,
   output logic                     if_id_flush,
   output logic                     id_ex_flush,
   output logic                     pc_redirect,
   output logic [PC_WIDTH-1:0]      pc_redirect_target,
   output logic                     busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   input  logic                     perf_clr,
   output logic [15:0]              perf_stall_cnt,
   output logic [15:0]              perf_flush_cnt
`endif
);

   localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
   localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

   hz_state_t             state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [PC_WIDTH-1:0]   target_q, target_d;
   logic                  load_use, br_take;
   logic                  stall, flush_if, flush_ex, redirect;

   assign load_use = ex_mem_read && (ex_rt != REGADDR_WIDTH'(ZERO_REG)) &&
                     ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
   assign br_take  = ex_branch && ex_branch_taken;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      stall    = 1'b0;
      flush_if = 1'b0;
      flush_ex = 1'b0;
      redirect = 1'b0;
      // The branch in EX is older than anything in ID, so it overrides every state.
      if (br_take) begin
         redirect = 1'b1;
         flush_if = 1'b1;
         flush_ex = 1'b1;
         target_d = ex_branch_target;
         if (FLUSH_CYCLES > 1) begin
            state_d = BR_FLUSH;
            cnt_d   = FL_RELOAD;
         end else begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end else begin
         unique case (state_q)
            RUN: begin
               if (load_use) begin
                  stall    = 1'b1;
                  flush_ex = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_d = LD_STALL;
                     cnt_d   = LD_RELOAD;
                  end
               end
            end
            LD_STALL: begin
               stall    = 1'b1;
               flush_ex = 1'b1;
               cnt_d    = cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_d = RUN;
            end
            BR_FLUSH: begin
               flush_if = 1'b1;
               flush_ex = 1'b1;
               cnt_d    = cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_d = RUN;
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= RUN;
         cnt_q    <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
      end
   end

   // Outputs are combinational on live inputs, so reset must mask them directly.
   assign pc_stall           = reset_n && stall;
   assign if_id_stall        = reset_n && stall;
   assign if_id_flush        = reset_n && flush_if;
   assign id_ex_flush        = reset_n && flush_ex;
   assign pc_redirect        = reset_n && redirect;
   assign pc_redirect_target = (reset_n && redirect) ? ex_branch_target : target_q;
   assign busy               = (state_q != RUN);

   always_ff @(posedge clk) begin
      assert ((LOAD_STALL_CYCLES >= 1) && (LOAD_STALL_CYCLES <= 7) &&
              (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 7))
         else $error("pipeline_hazard_ctrl: cycle-count parameter outside 1..7");
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counter u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (perf_clr),
      .inc     (pc_stall),
      .count   (perf_stall_cnt)
   );

   hazard_perf_counter u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (perf_clr),
      .inc     (if_id_flush),
      .count   (perf_flush_cnt)
   );
`endif

endmodule
